// File: rtl/i2c_uart_cmd_sched_if.sv
// rtl/i2c_uart_cmd_sched_if.sv - UART byte handshake and i2c_ctrl transaction signals of the command sequencer
interface i2c_uart_cmd_sched_if;
    logic        RX_RDY;
    logic [7:0]  uart_rx;
    logic        OEN;
    logic        TX_RDY;
    logic [7:0]  uart_tx;
    logic        WEN;
    logic        i2c_end;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic        rd_en;
    logic        i2c_start;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data;
    logic        busy;

    modport master (
        input  RX_RDY, uart_rx, TX_RDY, i2c_end, rd_data,
        output OEN, uart_tx, WEN, wr_en, rd_en, i2c_start, byte_addr, wr_data, busy
    );

    modport slave (
        output RX_RDY, uart_rx, TX_RDY, i2c_end, rd_data,
        input  OEN, uart_tx, WEN, wr_en, rd_en, i2c_start, byte_addr, wr_data, busy
    );
endinterface

// File: rtl/i2c_uart_cmd_sched.sv
// rtl/i2c_uart_cmd_sched.sv - UART-framed 'W'/'R' command sequencer driving i2c_ctrl with write hold-off and timeout
// Define I2C_SCHED_WR_ACK_EN to send an ACK byte (0x06) when the post-write hold-off expires.
module i2c_uart_cmd_sched #(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned WR_HOLD_US   = 5000,
    parameter int unsigned TIMEOUT_CYC  = 2_000_000,
    parameter logic [7:0]  ERR_CODE     = 8'hEE
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_uart_cmd_sched_if.master bus
);
    localparam logic [31:0] HOLD_LAST    = 32'(SYS_CLK_FREQ / 1_000_000 * WR_HOLD_US - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  CMD_W        = 8'h57;
    localparam logic [7:0]  CMD_R        = 8'h52;
    localparam logic [7:0]  ACK_BYTE     = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_AH, S_GET_AL, S_GET_D, S_START, S_WAIT, S_HOLD, S_TX
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  uart_tx_q, uart_tx_d;
    logic        wen_q, wen_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        start_q, start_d;
    logic [31:0] cnt_q, cnt_d;
    logic        oen_block_q;
    logic        accept;
    logic        pop;

    // oen_block_q forces OEN high for a cycle after every pop; it resets high so OEN stays inactive during reset
    always_comb begin
        accept = (state_q == S_IDLE) || (state_q == S_GET_AH) ||
                 (state_q == S_GET_AL) || (state_q == S_GET_D);
        pop    = accept && bus.RX_RDY && !oen_block_q;
    end

    always_comb begin
        state_d   = state_q;
        cmd_wr_d  = cmd_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_byte_d = tx_byte_q;
        uart_tx_d = uart_tx_q;
        wen_d     = 1'b1;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        start_d   = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop && bus.uart_rx == CMD_W) begin
                    cmd_wr_d = 1'b1;
                    state_d  = S_GET_AH;
                end else if (pop && bus.uart_rx == CMD_R) begin
                    cmd_wr_d = 1'b0;
                    state_d  = S_GET_AH;
                end
            end
            S_GET_AH: begin
                if (pop) begin
                    addr_d[15:8] = bus.uart_rx;
                    state_d      = S_GET_AL;
                end
            end
            S_GET_AL: begin
                if (pop) begin
                    addr_d[7:0] = bus.uart_rx;
                    state_d     = cmd_wr_q ? S_GET_D : S_START;
                end
            end
            S_GET_D: begin
                if (pop) begin
                    wdata_d = bus.uart_rx;
                    state_d = S_START;
                end
            end
            S_START: begin
                wr_en_d = cmd_wr_q;
                rd_en_d = !cmd_wr_q;
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // i2c_end is tested first so it wins over a coincident timeout
                if (bus.i2c_end) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    cnt_d   = '0;
                    if (cmd_wr_q) begin
                        state_d = S_HOLD;
                    end else begin
                        tx_byte_d = bus.rd_data;
                        state_d   = S_TX;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    wr_en_d   = 1'b0;
                    rd_en_d   = 1'b0;
                    cnt_d     = '0;
                    tx_byte_d = ERR_CODE;
                    state_d   = S_TX;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
`ifdef I2C_SCHED_WR_ACK_EN
                    tx_byte_d = ACK_BYTE;
                    state_d   = S_TX;
`else
                    state_d   = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_TX: begin
                if (bus.TX_RDY) begin
                    uart_tx_d = tx_byte_q;
                    wen_d     = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_wr_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tx_byte_q   <= '0;
            uart_tx_q   <= '0;
            wen_q       <= 1'b1;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            oen_block_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_wr_q    <= cmd_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_byte_q   <= tx_byte_d;
            uart_tx_q   <= uart_tx_d;
            wen_q       <= wen_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            oen_block_q <= pop;
        end
    end

    assign bus.OEN       = !pop;
    assign bus.uart_tx   = uart_tx_q;
    assign bus.WEN       = wen_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.i2c_start = start_q;
    assign bus.byte_addr = addr_q;
    assign bus.wr_data   = wdata_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
